id_ex_forward_stage: RTL and testbench

ID/EX pipeline register for the five-stage pipelined CPU. It also contains the forwarding unit and load-use hazard detection, and drives the select inputs of the two 3-input 32-bit operand multiplexers at the head of EX. It latches decoded operands and control from ID. It produces registered EX-side values plus combinational forwarding selects and a stall request back to PC/IF-ID. It also inserts bubbles on hazards or flushes, and counts them.

---
 rtl/id_ex_forward_stage.sv | 161 ++++++++++++++++
 tb/tb_id_ex_forward_stage.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_forward_stage.sv
// id_ex_forward_stage: ID/EX pipeline register with forwarding select
// generation, load-use hazard detection and a bubble counter.
// Define FORWARD_EN to enable operand forwarding. Without it, the
// forwarding selects stay at the register file, and RAW hazards against
// EX and EX/MEM producers stall instead.
module id_ex_forward_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic [WIDTH-1:0]   rs_data_i,
    input  logic [WIDTH-1:0]   rt_data_i,
    input  logic [WIDTH-1:0]   imm_i,
    input  logic [4:0]         rs_addr_i,
    input  logic [4:0]         rt_addr_i,
    input  logic [4:0]         rd_addr_i,
    input  logic [7:0]         ctrl_i,
    input  logic               exmem_regwrite_i,
    input  logic [4:0]         exmem_rd_i,
    input  logic               memwb_regwrite_i,
    input  logic [4:0]         memwb_rd_i,
    output logic [WIDTH-1:0]   rs_data_o,
    output logic [WIDTH-1:0]   rt_data_o,
    output logic [WIDTH-1:0]   imm_o,
    output logic [4:0]         rs_addr_o,
    output logic [4:0]         rt_addr_o,
    output logic [4:0]         dst_addr_o,
    output logic [7:0]         ctrl_o,
    output logic               valid_o,
    output logic [1:0]         fwd_a_o,
    output logic [1:0]         fwd_b_o,
    output logic               hazard_o,
    output logic [15:0]        bubble_cnt_o
);

    localparam int unsigned CNT_W = 16;
    localparam logic [1:0] SEL_RF = 2'b00;
    localparam logic [1:0] SEL_WB = 2'b01;
    localparam logic [1:0] SEL_EX = 2'b10;

    // Control bit positions within ctrl_i / ctrl_o
    localparam int unsigned C_REGWRITE = 7;
    localparam int unsigned C_MEMREAD  = 5;
    localparam int unsigned C_REGDST   = 0;

    logic       bubble_c;
    logic [4:0] dst_next_c;
    logic       load_use_c;

    assign bubble_c   = flush_i | hazard_o;
    assign dst_next_c = ctrl_i[C_REGDST] ? rd_addr_i : rt_addr_i;

    // A load in EX whose destination is read by the instruction in ID
    always_comb begin
        load_use_c = 1'b0;
        if (valid_o && ctrl_o[C_MEMREAD] && (dst_addr_o != 5'd0) &&
            ((dst_addr_o == rs_addr_i) || (dst_addr_o == rt_addr_i))) begin
            load_use_c = 1'b1;
        end
    end

`ifdef FORWARD_EN
    // Pick the youngest producer of a source register; r0 is never forwarded
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic       ex_we,
                                           input logic [4:0] ex_rd,
                                           input logic       wb_we,
                                           input logic [4:0] wb_rd);
        logic [1:0] sel;
        sel = SEL_RF;
        if (ex_we && (ex_rd != 5'd0) && (ex_rd == src)) begin
            sel = SEL_EX;
        end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == src)) begin
            sel = SEL_WB;
        end
        return sel;
    endfunction

    // Forwarding selects for both EX operands
    always_comb begin
        fwd_a_o = fwd_sel(rs_addr_o, exmem_regwrite_i, exmem_rd_i,
                          memwb_regwrite_i, memwb_rd_i);
        fwd_b_o = fwd_sel(rt_addr_o, exmem_regwrite_i, exmem_rd_i,
                          memwb_regwrite_i, memwb_rd_i);
    end

    // Only loads need a stall when forwarding is available
    always_comb begin
        hazard_o = load_use_c;
    end
`else
    logic raw_ex_c;
    logic raw_mem_c;
    logic unused_fwd_inputs;

    // MEM/WB results reach ID through the write-first register file
    assign unused_fwd_inputs = ^{memwb_regwrite_i, memwb_rd_i, SEL_WB, SEL_EX};

    // Selects never leave the register file
    always_comb begin
        fwd_a_o = SEL_RF;
        fwd_b_o = SEL_RF;
    end

    // Any RAW dependence on the EX or EX/MEM producer stalls the ID instruction
    always_comb begin
        raw_ex_c  = 1'b0;
        raw_mem_c = 1'b0;
        if (valid_o && ctrl_o[C_REGWRITE] &&
            (((rs_addr_i != 5'd0) && (rs_addr_i == dst_addr_o)) ||
             ((rt_addr_i != 5'd0) && (rt_addr_i == dst_addr_o)))) begin
            raw_ex_c = 1'b1;
        end
        if (exmem_regwrite_i &&
            (((rs_addr_i != 5'd0) && (rs_addr_i == exmem_rd_i)) ||
             ((rt_addr_i != 5'd0) && (rt_addr_i == exmem_rd_i)))) begin
            raw_mem_c = 1'b1;
        end
        hazard_o = load_use_c | raw_ex_c | raw_mem_c;
    end
`endif

    // Pipeline register: stall holds, flush/hazard inserts a counted bubble
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rs_data_o    <= '0;
            rt_data_o    <= '0;
            imm_o        <= '0;
            rs_addr_o    <= '0;
            rt_addr_o    <= '0;
            dst_addr_o   <= '0;
            ctrl_o       <= '0;
            valid_o      <= 1'b0;
            bubble_cnt_o <= '0;
        end else if (!stall_i) begin
            if (bubble_c) begin
                rs_data_o    <= '0;
                rt_data_o    <= '0;
                imm_o        <= '0;
                rs_addr_o    <= '0;
                rt_addr_o    <= '0;
                dst_addr_o   <= '0;
                ctrl_o       <= '0;
                valid_o      <= 1'b0;
                bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
            end else begin
                rs_data_o    <= rs_data_i;
                rt_data_o    <= rt_data_i;
                imm_o        <= imm_i;
                rs_addr_o    <= rs_addr_i;
                rt_addr_o    <= rt_addr_i;
                dst_addr_o   <= dst_next_c;
                ctrl_o       <= ctrl_i;
                valid_o      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_forward_stage.sv
// Testbench for id_ex_forward_stage: directed vectors, hand sequences for
// hazards/stall/flush/counter wrap, and a randomized run against a model.
module tb_id_ex_forward_stage;

`ifdef FORWARD_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i;
    logic        stall_i, flush_i;
    logic [31:0] rs_data_i, rt_data_i, imm_i;
    logic [4:0]  rs_addr_i, rt_addr_i, rd_addr_i;
    logic [7:0]  ctrl_i;
    logic        exmem_regwrite_i, memwb_regwrite_i;
    logic [4:0]  exmem_rd_i, memwb_rd_i;
    logic [31:0] rs_data_o, rt_data_o, imm_o;
    logic [4:0]  rs_addr_o, rt_addr_o, dst_addr_o;
    logic [7:0]  ctrl_o;
    logic        valid_o, hazard_o;
    logic [1:0]  fwd_a_o, fwd_b_o;
    logic [15:0] bubble_cnt_o;

    int checks   = 0;
    int failures = 0;

    id_ex_forward_stage #(.WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
        .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .rd_addr_i(rd_addr_i),
        .ctrl_i(ctrl_i),
        .exmem_regwrite_i(exmem_regwrite_i), .exmem_rd_i(exmem_rd_i),
        .memwb_regwrite_i(memwb_regwrite_i), .memwb_rd_i(memwb_rd_i),
        .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .imm_o(imm_o),
        .rs_addr_o(rs_addr_o), .rt_addr_o(rt_addr_o), .dst_addr_o(dst_addr_o),
        .ctrl_o(ctrl_o), .valid_o(valid_o),
        .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .hazard_o(hazard_o),
        .bubble_cnt_o(bubble_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [7:0] ctrl, input logic [31:0] rsd);
        rs_addr_i = rs; rt_addr_i = rt; rd_addr_i = rd; ctrl_i = ctrl;
        rs_data_i = rsd; rt_data_i = rsd ^ 32'h5555_0000; imm_i = ~rsd;
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] er, input logic ww, input logic [4:0] wr);
        exmem_regwrite_i = ew; exmem_rd_i = er; memwb_regwrite_i = ww; memwb_rd_i = wr;
    endtask

    // ---------------- reference model of the EX slot ----------------
    typedef struct {
        bit        valid;
        bit [31:0] rsd, rtd, imm;
        bit [4:0]  rsa, rta, dst;
        bit [7:0]  ctrl;
    } slot_t;

    slot_t m_slot;
    int    m_cnt;

    function automatic bit reads(input bit [4:0] r, input bit nz);
        // true when the ID instruction names register r as a source
        return (!nz || r != 0) && (rs_addr_i == r || rt_addr_i == r);
    endfunction

    function automatic bit m_hazard();
        bit h;
        h = m_slot.valid && m_slot.ctrl[5] && m_slot.dst != 0 && reads(m_slot.dst, 1'b0);
        if (!FE) begin
            h = h || (m_slot.valid && m_slot.ctrl[7] &&
                      ((rs_addr_i != 0 && rs_addr_i == m_slot.dst) ||
                       (rt_addr_i != 0 && rt_addr_i == m_slot.dst)));
            h = h || (exmem_regwrite_i &&
                      ((rs_addr_i != 0 && rs_addr_i == exmem_rd_i) ||
                       (rt_addr_i != 0 && rt_addr_i == exmem_rd_i)));
        end
        return h;
    endfunction

    function automatic bit [1:0] m_fwd(input bit [4:0] src);
        if (!FE) return 2'b00;
        if (exmem_regwrite_i && exmem_rd_i != 0 && exmem_rd_i == src) return 2'b10;
        if (memwb_regwrite_i && memwb_rd_i != 0 && memwb_rd_i == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic m_clock(input bit hz);
        if (stall_i) return;
        if (flush_i || hz) begin
            m_slot = '{default: '0};
            m_cnt  = (m_cnt + 1) % 65536;
        end else begin
            m_slot.valid = 1;
            m_slot.rsd = rs_data_i; m_slot.rtd = rt_data_i; m_slot.imm = imm_i;
            m_slot.rsa = rs_addr_i; m_slot.rta = rt_addr_i;
            m_slot.dst = ctrl_i[0] ? rd_addr_i : rt_addr_i;
            m_slot.ctrl = ctrl_i;
        end
    endtask

    // ---------------- forwarding vector table ----------------
    typedef struct {
        logic [4:0] rs, rt;
        logic       ew;
        logic [4:0] er;
        logic       ww;
        logic [4:0] wr;
        logic [1:0] a, b;
    } fwd_vec_t;

    fwd_vec_t vecs[7];
    int       cnt_exp;
    bit       hz;

    initial begin
        vecs[0] = '{5'd5, 5'd6, 1'b1, 5'd5, 1'b1, 5'd5, 2'b10, 2'b00};
        vecs[1] = '{5'd5, 5'd6, 1'b0, 5'd5, 1'b1, 5'd5, 2'b01, 2'b00};
        vecs[2] = '{5'd5, 5'd6, 1'b1, 5'd6, 1'b1, 5'd5, 2'b01, 2'b10};
        vecs[3] = '{5'd5, 5'd6, 1'b1, 5'd7, 1'b0, 5'd6, 2'b00, 2'b00};
        vecs[4] = '{5'd0, 5'd5, 1'b1, 5'd0, 1'b1, 5'd0, 2'b00, 2'b00};
        vecs[5] = '{5'd0, 5'd5, 1'b1, 5'd0, 1'b1, 5'd5, 2'b00, 2'b01};
        vecs[6] = '{5'd7, 5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 2'b10, 2'b10};

        // Reset with every input nonzero
        rst_i = 1'b0; stall_i = 1'b1; flush_i = 1'b1;
        set_id(5'd3, 5'd4, 5'd5, 8'hFF, 32'hDEAD_BEEF);
        set_fwd(1'b1, 5'd9, 1'b1, 5'd10);
        tick(); tick();
        chk("rst_rs_data", rs_data_o, 0);
        chk("rst_rt_data", rt_data_o, 0);
        chk("rst_imm", imm_o, 0);
        chk("rst_addrs", {rs_addr_o, rt_addr_o, dst_addr_o}, 0);
        chk("rst_ctrl", ctrl_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_cnt", bubble_cnt_o, 0);
        chk("rst_comb", {fwd_a_o, fwd_b_o, hazard_o}, 0);

        // First edge after release performs a normal load
        stall_i = 0; flush_i = 0; set_fwd(0, 0, 0, 0);
        set_id(5'd1, 5'd2, 5'd3, 8'h00, 32'h0000_1234);
        @(negedge clk); rst_i = 1'b1;
        tick();
        chk("first_rs_data", rs_data_o, 32'h1234);
        chk("first_valid", valid_o, 1);
        chk("first_imm", imm_o, ~32'h1234);

        // Forwarding selects from the vector table
        foreach (vecs[i]) begin
            set_fwd(0, 0, 0, 0);
            set_id(vecs[i].rs, vecs[i].rt, 5'd12, 8'h00, 32'(i));
            tick();
            chk($sformatf("vec%0d_rs_addr", i), rs_addr_o, vecs[i].rs);
            set_id(5'd0, 5'd0, 5'd0, 8'h00, 32'(i));
            set_fwd(vecs[i].ew, vecs[i].er, vecs[i].ww, vecs[i].wr);
            #1;
            chk($sformatf("vec%0d_fwd_a", i), fwd_a_o, FE ? vecs[i].a : 2'b00);
            chk($sformatf("vec%0d_fwd_b", i), fwd_b_o, FE ? vecs[i].b : 2'b00);
        end
        set_fwd(0, 0, 0, 0);

        // Load-use: lw r8, then a reader of r8
        set_id(5'd2, 5'd8, 5'd9, 8'hE8, 32'h0000_0100);
        tick();
        chk("lw_dst", dst_addr_o, 8);
        set_id(5'd1, 5'd8, 5'd10, 8'h81, 32'h0000_0200);
        #1;
        chk("lu_hazard", hazard_o, 1);
        tick();
        chk("lu_bubble_ctrl", ctrl_o, 0);
        chk("lu_bubble_valid", valid_o, 0);
        chk("lu_bubble_data", rs_data_o, 0);
        chk("lu_bubble_cnt", bubble_cnt_o, 1);
        chk("lu_hazard_clear", hazard_o, 0);
        tick();
        chk("lu_consumer_valid", valid_o, 1);
        chk("lu_consumer_dst", dst_addr_o, 10);
        chk("lu_consumer_data", rs_data_o, 32'h200);
        cnt_exp = 1;

        // Stall beats flush; flush applies on the first unstalled edge
        stall_i = 1; flush_i = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("stall%0d_cnt", k), bubble_cnt_o, 16'(cnt_exp));
            chk($sformatf("stall%0d_hold", k), {valid_o, dst_addr_o, rs_data_o}, {1'b1, 5'd10, 32'h200});
        end
        stall_i = 0;
        tick();
        cnt_exp++;
        chk("flush_valid", valid_o, 0);
        chk("flush_cnt", bubble_cnt_o, 16'(cnt_exp));
        flush_i = 0;

`ifndef FORWARD_EN
        // ALU producer of r3, then reader of r3: two stall cycles
        set_id(5'd4, 5'd5, 5'd3, 8'h81, 32'h0000_0300);
        tick();
        set_id(5'd3, 5'd4, 5'd11, 8'h80, 32'h0000_0400);
        #1;
        chk("nf_hazard_ex", hazard_o, 1);
        chk("nf_fwd", {fwd_a_o, fwd_b_o}, 0);
        tick();
        cnt_exp++;
        chk("nf_bubble1", {valid_o, bubble_cnt_o}, {1'b0, 16'(cnt_exp)});
        set_fwd(1, 5'd3, 0, 0);
        #1;
        chk("nf_hazard_mem", hazard_o, 1);
        chk("nf_fwd_mem", {fwd_a_o, fwd_b_o}, 0);
        tick();
        cnt_exp++;
        chk("nf_bubble2", {valid_o, bubble_cnt_o}, {1'b0, 16'(cnt_exp)});
        set_fwd(0, 0, 1, 5'd3);
        #1;
        chk("nf_hazard_wb", hazard_o, 0);
        tick();
        chk("nf_consumer", {valid_o, rs_addr_o}, {1'b1, 5'd3});
        set_fwd(0, 0, 0, 0);
`else
        // ALU producer of r3, reader of r3 proceeds and forwards from EX/MEM
        set_id(5'd4, 5'd5, 5'd3, 8'h81, 32'h0000_0300);
        tick();
        set_id(5'd3, 5'd4, 5'd11, 8'h80, 32'h0000_0400);
        #1;
        chk("fw_no_hazard", hazard_o, 0);
        tick();
        set_fwd(1, 5'd3, 0, 0);
        #1;
        chk("fw_consumer", {valid_o, rs_addr_o, bubble_cnt_o}, {1'b1, 5'd3, 16'(cnt_exp)});
        chk("fw_sel", {fwd_a_o, fwd_b_o}, {2'b10, 2'b00});
        set_fwd(0, 0, 0, 0);
`endif

        // Asynchronous reset mid-cycle
        @(posedge clk); #3;
        rst_i = 0;
        #1;
        chk("midrst_valid", valid_o, 0);
        chk("midrst_cnt", bubble_cnt_o, 0);
        chk("midrst_data", {rs_addr_o, rs_data_o}, 0);
        m_slot = '{default: '0};
        m_cnt  = 0;
        @(negedge clk); rst_i = 1;

        // Randomized run against the model
        for (int n = 0; n < 400; n++) begin
            stall_i = ($urandom_range(0, 5) == 0);
            flush_i = ($urandom_range(0, 7) == 0);
            set_id(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 8'($urandom), $urandom);
            rt_data_i = $urandom; imm_i = $urandom;
            set_fwd(1'($urandom), 5'($urandom_range(0, 7)),
                    1'($urandom), 5'($urandom_range(0, 7)));
            #1;
            hz = m_hazard();
            chk("rnd_hazard", hazard_o, hz);
            chk("rnd_fwd_a", fwd_a_o, m_fwd(m_slot.rsa));
            chk("rnd_fwd_b", fwd_b_o, m_fwd(m_slot.rta));
            @(posedge clk);
            m_clock(hz);
            #1;
            chk("rnd_valid", valid_o, m_slot.valid);
            chk("rnd_ctrl", ctrl_o, m_slot.ctrl);
            chk("rnd_addrs", {rs_addr_o, rt_addr_o, dst_addr_o}, {m_slot.rsa, m_slot.rta, m_slot.dst});
            chk("rnd_data", rs_data_o ^ rt_data_o ^ imm_o, m_slot.rsd ^ m_slot.rtd ^ m_slot.imm);
            chk("rnd_cnt", bubble_cnt_o, 16'(m_cnt));
        end

        // Counter wrap: flush up to 0xFFFF, then once more
        stall_i = 0; flush_i = 1; set_fwd(0, 0, 0, 0);
        for (int k = 0; k < (65535 - m_cnt); k++) @(posedge clk);
        #1;
        chk("cnt_max", bubble_cnt_o, 16'hFFFF);
        tick();
        chk("cnt_wrap", bubble_cnt_o, 16'h0000);
        flush_i = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
